pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator: CHANNELS outputs share one prescaled period counter, each compared against its own duty value. Edge-aligned and centre-aligned counting, programmable period, and double-buffered duty/period/mode registers that take effect only at a period boundary, so outputs never glitch. Drives heater/LED/fan control channels; the host side writes settings and pulses a load strobe.

---
 rtl/pwm_multi_if.sv | 27 ++
 rtl/pwm_multi.sv | 139 +++++++++++++
 tb/tb_pwm_multi.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// Host-side bundle for pwm_multi: settings, load strobe and the PWM/status outputs.
interface pwm_multi_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8
);
    logic                      enable;
    logic [DIV_W-1:0]          prescale;
    logic [WIDTH-1:0]          period_in;
    logic                      center_in;
    logic [CHANNELS*WIDTH-1:0] duty_in;
    logic                      duty_load;
    logic [CHANNELS-1:0]       ch_en;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_start;
    logic                      load_pending;

    modport master (
        output enable, prescale, period_in, center_in, duty_in, duty_load, ch_en,
        input  pwm_out, period_start, load_pending
    );

    modport slave (
        input  enable, prescale, period_in, center_in, duty_in, duty_load, ch_en,
        output pwm_out, period_start, load_pending
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaled edge/centre counter, per-channel
// duty compare, double-buffered settings that switch over only at a period boundary.
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    pwm_multi_if.slave  bus
);
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

    logic [DIV_W-1:0]          r_pcnt;
    logic [WIDTH-1:0]          r_cnt;
    logic                      r_down;
    logic [WIDTH-1:0]          r_per_sh;
    logic [WIDTH-1:0]          r_per_act;
    logic                      r_ctr_sh;
    logic                      r_ctr_act;
    logic [CHANNELS*WIDTH-1:0] r_duty_sh;
    logic [CHANNELS*WIDTH-1:0] r_duty_act;
    logic                      r_pend;
    logic                      r_new;
    logic [CHANNELS-1:0]       r_pwm;
    logic                      r_ps;

    logic                      w_tick;
    logic                      w_bound;
    logic [CHANNELS-1:0]       w_raw;

    // Prescaler tick and period-boundary detection; P = 1 centre has no down-count state.
    always_comb begin
        w_tick  = (r_pcnt == bus.prescale);
        w_bound = 1'b0;
        if (!w_tick) begin
            w_bound = 1'b0;
        end else if (r_per_act == CNT_ZERO) begin
            w_bound = 1'b1;
        end else if (r_ctr_act) begin
            w_bound = (r_cnt == CNT_ONE) && (r_down || (r_per_act == CNT_ONE));
        end else begin
            w_bound = (r_cnt == r_per_act);
        end
    end

    // Per-channel unsigned duty compare against the shared counter.
    always_comb begin
        w_raw = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            w_raw[i] = (r_duty_act[i*WIDTH +: WIDTH] > r_cnt);
        end
    end

    // Prescaler and period counter; pcnt above a lowered prescale wraps through all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= DIV_ZERO;
            r_cnt  <= CNT_ZERO;
            r_down <= 1'b0;
        end else if (!bus.enable) begin
            r_pcnt <= DIV_ZERO;
            r_cnt  <= CNT_ZERO;
            r_down <= 1'b0;
        end else if (w_tick) begin
            r_pcnt <= DIV_ZERO;
            if (w_bound) begin
                r_cnt  <= CNT_ZERO;
                r_down <= 1'b0;
            end else if (!r_ctr_act) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else if (r_down) begin
                r_cnt <= r_cnt - CNT_ONE;
            end else if (r_cnt == r_per_act) begin
                r_cnt  <= r_cnt - CNT_ONE;
                r_down <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end else begin
            r_pcnt <= r_pcnt + DIV_ONE;
        end
    end

    // Shadow/active double buffer; a load coinciding with a boundary stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_sh   <= {WIDTH{1'b1}};
            r_per_act  <= {WIDTH{1'b1}};
            r_ctr_sh   <= 1'b0;
            r_ctr_act  <= 1'b0;
            r_duty_sh  <= {(CHANNELS*WIDTH){1'b0}};
            r_duty_act <= {(CHANNELS*WIDTH){1'b0}};
            r_pend     <= 1'b0;
        end else begin
            if (bus.duty_load) begin
                r_per_sh  <= bus.period_in;
                r_ctr_sh  <= bus.center_in;
                r_duty_sh <= bus.duty_in;
            end
            if (!bus.enable || w_bound) begin
                r_per_act  <= r_per_sh;
                r_ctr_act  <= r_ctr_sh;
                r_duty_act <= r_duty_sh;
            end
            if (bus.duty_load) begin
                r_pend <= 1'b1;
            end else if (!bus.enable || w_bound) begin
                r_pend <= 1'b0;
            end else begin
                r_pend <= r_pend;
            end
        end
    end

    // Registered outputs; r_new marks that the next output cycle opens a period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= {CHANNELS{1'b0}};
            r_ps  <= 1'b0;
            r_new <= 1'b1;
        end else if (!bus.enable) begin
            r_pwm <= {CHANNELS{1'b0}};
            r_ps  <= 1'b0;
            r_new <= 1'b1;
        end else begin
            r_pwm <= w_raw & bus.ch_en;
            r_ps  <= r_new;
            r_new <= w_bound;
        end
    end

    assign bus.pwm_out      = r_pwm;
    assign bus.period_start = r_ps;
    assign bus.load_pending = r_pend;
endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: table of full-period high/pulse counts plus
// hand sequences for buffered updates, gating, disable and reset.
module tb_pwm_multi;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int DIV_W    = 8;

    typedef struct {
        logic [7:0]        pre;
        logic [7:0]        per;
        logic              ctr;
        logic [31:0]       duty;
        logic [3:0]        en;
        int                win;
        logic [3:0][15:0]  exp_hi;
        int                exp_ps;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vecs[5];

    always #5 clk = ~clk;

    pwm_multi_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DIV_W(DIV_W)) bus ();

    pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic configure(input logic [7:0] pre, input logic [7:0] per, input logic ctr,
                             input logic [31:0] duty, input logic [3:0] en);
        bus.enable    = 1'b0;
        bus.prescale  = pre;
        bus.period_in = per;
        bus.center_in = ctr;
        bus.duty_in   = duty;
        bus.ch_en     = en;
        bus.duty_load = 1'b1;
        @(negedge clk);
        bus.duty_load = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;
    endtask

    task automatic wait_ps(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_start && n < 400);
        if (!bus.period_start) check({name, "_ps_timeout"}, 0, 1);
    endtask

    initial begin
        int hi[4];
        int psc;
        int ph[3];
        int n;

        vecs[0] = '{8'd0, 8'd9, 1'b0, {8'd255, 8'd10, 8'd3, 8'd0}, 4'hF, 30,
                    {16'd30, 16'd30, 16'd9, 16'd0}, 3};
        vecs[1] = '{8'd0, 8'd4, 1'b1, {8'd4, 8'd3, 8'd1, 8'd2}, 4'hF, 16,
                    {16'd14, 16'd10, 16'd2, 16'd6}, 2};
        vecs[2] = '{8'd3, 8'd3, 1'b0, {8'd1, 8'd4, 8'd0, 8'd2}, 4'b1101, 32,
                    {16'd8, 16'd32, 16'd0, 16'd16}, 2};
        vecs[3] = '{8'd0, 8'd0, 1'b0, {8'd0, 8'd200, 8'd1, 8'd0}, 4'hF, 5,
                    {16'd0, 16'd5, 16'd5, 16'd0}, 5};
        vecs[4] = '{8'd1, 8'd1, 1'b1, {8'd1, 8'd2, 8'd0, 8'd1}, 4'hF, 8,
                    {16'd4, 16'd8, 16'd0, 16'd4}, 2};

        bus.enable    = 1'b0;
        bus.prescale  = 8'd0;
        bus.period_in = 8'd0;
        bus.center_in = 1'b0;
        bus.duty_in   = 32'd0;
        bus.duty_load = 1'b0;
        bus.ch_en     = 4'h0;
        @(negedge clk);
        check("rst_pwm", int'(bus.pwm_out), 0);
        check("rst_ps", int'(bus.period_start), 0);
        check("rst_pend", int'(bus.load_pending), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            configure(vecs[v].pre, vecs[v].per, vecs[v].ctr, vecs[v].duty, vecs[v].en);
            wait_ps($sformatf("v%0d", v));
            for (int c = 0; c < 4; c++) hi[c] = 0;
            psc = 0;
            for (int s = 0; s < vecs[v].win; s++) begin
                if (s > 0) @(negedge clk);
                for (int c = 0; c < 4; c++) hi[c] += int'(bus.pwm_out[c]);
                psc += int'(bus.period_start);
            end
            for (int c = 0; c < 4; c++)
                check($sformatf("v%0d_hi%0d", v, c), hi[c], int'(vecs[v].exp_hi[c]));
            check($sformatf("v%0d_ps", v), psc, vecs[v].exp_ps);
        end

        // Mid-period load then a load on the boundary-tick clock.
        configure(8'd0, 8'd9, 1'b0, {8'd0, 8'd0, 8'd0, 8'd7}, 4'hF);
        wait_ps("upd");
        for (int k = 0; k < 3; k++) ph[k] = 0;
        for (int s = 0; s < 30; s++) begin
            ph[s / 10] += int'(bus.pwm_out[0]);
            if (s == 4)  check("upd_pend_after_load", int'(bus.load_pending), 1);
            if (s == 10) check("upd_pend_coincident", int'(bus.load_pending), 1);
            if (s == 10) check("upd_ps_p1", int'(bus.period_start), 1);
            if (s == 20) check("upd_pend_cleared", int'(bus.load_pending), 0);
            if (s == 20) check("upd_ps_p2", int'(bus.period_start), 1);
            bus.duty_load = (s == 3 || s == 8);
            if (s == 3) bus.duty_in = {8'd0, 8'd0, 8'd0, 8'd2};
            if (s == 8) bus.duty_in = {8'd0, 8'd0, 8'd0, 8'd9};
            @(negedge clk);
        end
        bus.duty_load = 1'b0;
        check("upd_hi_p0", ph[0], 7);
        check("upd_hi_p1", ph[1], 2);
        check("upd_hi_p2", ph[2], 9);

        // Channel gating, disable and re-enable restart.
        configure(8'd0, 8'd9, 1'b0, {4{8'd10}}, 4'hF);
        wait_ps("gate");
        @(negedge clk);
        check("gate_all", int'(bus.pwm_out), 15);
        bus.ch_en = 4'b1101;
        @(negedge clk);
        check("gate_ch1_off", int'(bus.pwm_out), 13);
        bus.ch_en = 4'hF;
        @(negedge clk);
        check("gate_ch1_on", int'(bus.pwm_out), 15);
        bus.enable = 1'b0;
        @(negedge clk);
        check("dis_pwm", int'(bus.pwm_out), 0);
        check("dis_ps", int'(bus.period_start), 0);
        bus.enable = 1'b1;
        @(negedge clk);
        check("reen_ps_first", int'(bus.period_start), 1);
        check("reen_pwm_first", int'(bus.pwm_out), 15);
        @(negedge clk);
        check("reen_ps_second", int'(bus.period_start), 0);
        repeat (9) @(negedge clk);
        check("reen_ps_next", int'(bus.period_start), 1);

        // Asynchronous reset while high; pending shadow must be discarded.
        bus.period_in = 8'd5;
        bus.duty_in   = 32'd0;
        bus.duty_load = 1'b1;
        @(negedge clk);
        bus.duty_load = 1'b0;
        check("prerst_pend", int'(bus.load_pending), 1);
        check("prerst_pwm", int'(bus.pwm_out), 15);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_pwm", int'(bus.pwm_out), 0);
        check("rst_async_pend", int'(bus.load_pending), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_ps", int'(bus.period_start), 1);
        n = 0;
        psc = 0;
        do begin
            @(negedge clk);
            n++;
            psc += int'(bus.pwm_out != 4'h0);
        end while (!bus.period_start && n < 300);
        check("postrst_period", n, 256);
        check("postrst_hi", psc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
